// File: rtl/register_bus_reader_if.sv
// Handshake and bus signal bundle between the register bus reader and its environment.
// The reader uses the master modport; the request source, response sink and slice bank use slave.
interface register_bus_reader_if #(
  parameter int NrOfBits  = 32,
  parameter int NrOfSlots = 4,
  parameter int AddrBits  = 2
);
  logic                 req_valid;
  logic                 req_ready;
  logic [AddrBits-1:0]  req_addr;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [NrOfBits-1:0]  rsp_data;
  logic                 rsp_err;
  logic [NrOfSlots-1:0] cs;
  logic [NrOfBits-1:0]  bus;

  modport master (
    input  req_valid, req_addr, rsp_ready, bus,
    output req_ready, rsp_valid, rsp_data, rsp_err, cs
  );

  modport slave (
    output req_valid, req_addr, rsp_ready, bus,
    input  req_ready, rsp_valid, rsp_data, rsp_err, cs
  );
endinterface

// File: rtl/register_bus_reader.sv
// Reading master for a shared tri-state bus of register slices: select one slice, let it settle, capture.
// Optional macro BUS_TURNAROUND_EN inserts one all-released tick between capture and response.
module register_bus_reader #(
  parameter int NrOfBits    = 32,
  parameter int NrOfSlots   = 4,
  parameter int AddrBits    = 2,
  parameter int SettleTicks = 1
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   Tick,
  register_bus_reader_if.master  bus_if
);

  localparam int                  CntBits   = (SettleTicks > 1) ? $clog2(SettleTicks) : 1;
  localparam logic [CntBits-1:0]  CntLoad   = CntBits'(SettleTicks - 1);
  localparam logic [AddrBits:0]   SlotLimit = (AddrBits + 1)'(NrOfSlots);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SELECT = 3'd1;
  localparam logic [2:0] ST_SAMPLE = 3'd2;
  localparam logic [2:0] ST_RESP   = 3'd3;
`ifdef BUS_TURNAROUND_EN
  localparam logic [2:0] ST_TURN   = 3'd4;
`endif

  logic [2:0]           state_q, state_d;
  logic [CntBits-1:0]   cnt_q, cnt_d;
  logic [NrOfSlots-1:0] cs_q, cs_d;
  logic [NrOfBits-1:0]  rsp_data_q, rsp_data_d;
  logic                 rsp_err_q, rsp_err_d;

  logic                 addr_ok;
  logic [NrOfSlots-1:0] sel_mask;

  // Active-low one-cold select for the requested slot; addresses past the bank select nothing.
  always_comb begin
    addr_ok  = {1'b0, bus_if.req_addr} < SlotLimit;
    sel_mask = '1;
    for (int i = 0; i < NrOfSlots; i++) begin
      if (AddrBits'(i) == bus_if.req_addr) begin
        sel_mask[i] = 1'b0;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cs_d       = cs_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;

    if (Tick) begin
      case (state_q)
        ST_IDLE: begin
          if (bus_if.req_valid) begin
            if (addr_ok) begin
              cs_d    = sel_mask;
              cnt_d   = CntLoad;
              state_d = ST_SELECT;
            end else begin
              rsp_data_d = '0;
              rsp_err_d  = 1'b1;
              state_d    = ST_RESP;
            end
          end
        end
        ST_SELECT: begin
          if (cnt_q == '0) begin
            state_d = ST_SAMPLE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_SAMPLE: begin
          rsp_data_d = bus_if.bus;
          rsp_err_d  = 1'b0;
          cs_d       = '1;
`ifdef BUS_TURNAROUND_EN
          state_d    = ST_TURN;
`else
          state_d    = ST_RESP;
`endif
        end
`ifdef BUS_TURNAROUND_EN
        ST_TURN: begin
          state_d = ST_RESP;
        end
`endif
        ST_RESP: begin
          if (bus_if.rsp_ready) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cs_d    = '1;
        end
      endcase
    end
  end

  // Reset releases every slice immediately so an aborted read never leaves a driver on the bus.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      cs_q       <= '1;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cs_q       <= cs_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign bus_if.req_ready = (state_q == ST_IDLE);
  assign bus_if.rsp_valid = (state_q == ST_RESP);
  assign bus_if.rsp_data  = rsp_data_q;
  assign bus_if.rsp_err   = rsp_err_q;
  assign bus_if.cs        = cs_q;

endmodule

// File: tb/tb_register_bus_reader.sv
// Scoreboard bench for register_bus_reader: requests push expected words and timing, a monitor checks them.
// The bus is modelled by OR-ing the words of every slice whose cs is low.
module tb_register_bus_reader;

  localparam int NrOfBits    = 32;
  localparam int NrOfSlots   = 3;
  localparam int AddrBits    = 2;
  localparam int SettleTicks = 2;
`ifdef BUS_TURNAROUND_EN
  localparam int TurnTicks   = 1;
`else
  localparam int TurnTicks   = 0;
`endif

  typedef struct {
    logic [NrOfBits-1:0] data;
    logic                err;
    int                  addr;
    int                  accept_tick;
  } exp_t;

  logic Clock       = 1'b0;
  logic Reset       = 1'b1;
  logic Tick        = 1'b0;
  logic reset_probe = 1'b0;

  exp_t                sb[$];
  logic [NrOfBits-1:0] slot_val [NrOfSlots];
  int                  tick_count;
  int                  accepted_cnt = 0;
  int                  taken_cnt    = 0;
  int                  vectors      = 0;
  int                  miscompares  = 0;
  int                  tick_mode    = 0;
  int                  ready_mode   = 0;

  exp_t                 mon_e;
  logic [NrOfSlots-1:0] exp_cs;
  logic                 exp_valid;
  logic [NrOfSlots-1:0] all_ones = '1;

  register_bus_reader_if #(
    .NrOfBits (NrOfBits),
    .NrOfSlots(NrOfSlots),
    .AddrBits (AddrBits)
  ) bus_if ();

  register_bus_reader #(
    .NrOfBits   (NrOfBits),
    .NrOfSlots  (NrOfSlots),
    .AddrBits   (AddrBits),
    .SettleTicks(SettleTicks)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .Tick  (Tick),
    .bus_if(bus_if.master)
  );

  always #5 Clock = ~Clock;

  always_comb begin
    bus_if.bus = '0;
    for (int i = 0; i < NrOfSlots; i++) begin
      if (!bus_if.cs[i]) begin
        bus_if.bus = bus_if.bus | slot_val[i];
      end
    end
  end

  // Model time base: counts the clock edges on which the reader is allowed to advance.
  always @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      tick_count <= 0;
    end else if (Tick) begin
      tick_count <= tick_count + 1;
    end
  end

  function automatic logic [NrOfSlots-1:0] slot_mask(input int addr);
    return ~(NrOfSlots'(1) << addr);
  endfunction

  function automatic int latency(input logic err);
    return err ? 0 : SettleTicks + 1 + TurnTicks;
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Tick and rsp_ready pattern generator, changing just after each rising edge.
  initial begin
    int cyc;
    cyc = 0;
    forever begin
      @(posedge Clock);
      #1;
      cyc++;
      case (tick_mode)
        0:       Tick = 1'b1;
        1:       Tick = (cyc % 3 == 0);
        default: Tick = 1'($urandom_range(0, 1));
      endcase
      case (ready_mode)
        0:       bus_if.rsp_ready = 1'b1;
        1:       bus_if.rsp_ready = ($urandom_range(0, 3) != 0);
        default: bus_if.rsp_ready = 1'b0;
      endcase
    end
  end

  // Monitor: derives cs, rsp_valid and req_ready from the head request's accept tick.
  initial begin
    forever begin
      @(negedge Clock or posedge reset_probe);
      if (reset_probe) begin
        check_output("reset_cs",        64'(bus_if.cs),        64'(all_ones));
        check_output("reset_rsp_valid", 64'(bus_if.rsp_valid), 64'(0));
        check_output("reset_req_ready", 64'(bus_if.req_ready), 64'(1));
        check_output("reset_rsp_data",  64'(bus_if.rsp_data),  64'(0));
        check_output("reset_rsp_err",   64'(bus_if.rsp_err),   64'(0));
      end else if (!Reset) begin
        exp_cs    = '1;
        exp_valid = 1'b0;
        if (sb.size() > 0) begin
          mon_e = sb[0];
          if (!mon_e.err && tick_count >= mon_e.accept_tick &&
              tick_count <= mon_e.accept_tick + SettleTicks) begin
            exp_cs = slot_mask(mon_e.addr);
          end
          exp_valid = (tick_count >= mon_e.accept_tick + latency(mon_e.err));
        end
        check_output("cs",        64'(bus_if.cs),        64'(exp_cs));
        check_output("rsp_valid", 64'(bus_if.rsp_valid), 64'(exp_valid));
        check_output("req_ready", 64'(bus_if.req_ready), 64'(accepted_cnt == taken_cnt));
        if (exp_valid) begin
          check_output("rsp_data", 64'(bus_if.rsp_data), 64'(mon_e.data));
          check_output("rsp_err",  64'(bus_if.rsp_err),  64'(mon_e.err));
          if (bus_if.rsp_ready && Tick) begin
            void'(sb.pop_front());
            taken_cnt <= taken_cnt + 1;
          end
        end
      end
    end
  end

  // Holds a request until the model says the reader is idle on a tick, then records the expectation.
  task automatic apply_stimulus(input int addr, input bit rand_slots);
    exp_t e;
    @(posedge Clock);
    #2;
    if (rand_slots && sb.size() == 0) begin
      for (int i = 0; i < NrOfSlots; i++) begin
        slot_val[i] = $urandom();
      end
    end
    bus_if.req_addr  = AddrBits'(addr);
    bus_if.req_valid = 1'b1;
    for (int n = 0; n < 500; n++) begin
      @(negedge Clock);
      if (accepted_cnt == taken_cnt && Tick) begin
        e.err  = (addr >= NrOfSlots);
        e.data = '0;
        if (addr < NrOfSlots) begin
          e.data = slot_val[addr];
        end
        e.addr        = addr;
        e.accept_tick = tick_count + 1;
        sb.push_back(e);
        accepted_cnt <= accepted_cnt + 1;
        @(posedge Clock);
        #2;
        bus_if.req_valid = 1'b0;
        bus_if.req_addr  = AddrBits'($urandom());
        return;
      end
    end
    $display("[TB] FAIL request_accept: got no acceptance expected acceptance within 500 cycles");
    $fatal(1, "[TB] request never accepted");
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 500; n++) begin
      if (sb.size() == 0 && accepted_cnt == taken_cnt) begin
        return;
      end
      @(negedge Clock);
    end
    $display("[TB] FAIL wait_idle: got busy expected idle within 500 cycles");
    $fatal(1, "[TB] model never drained");
  endtask

  initial begin
    bus_if.req_valid = 1'b0;
    bus_if.req_addr  = '0;
    bus_if.rsp_ready = 1'b0;
    slot_val[0] = 32'h0000_0055;
    slot_val[1] = 32'hCAFE_0001;
    slot_val[2] = 32'hDEAD_BEEF;

    #12 reset_probe = 1'b1;
    #1  reset_probe = 1'b0;
    @(negedge Clock);
    #2 Reset = 1'b0;

    $display("[TB] directed reads, Tick every cycle");
    apply_stimulus(2, 0);
    wait_idle();
    apply_stimulus(3, 0);
    wait_idle();
    apply_stimulus(1, 0);
    wait_idle();

    $display("[TB] Tick every third cycle, slot 0");
    tick_mode = 1;
    apply_stimulus(0, 0);
    wait_idle();
    tick_mode = 0;

    $display("[TB] held response with a queued request");
    ready_mode = 2;
    apply_stimulus(1, 0);
    fork
      apply_stimulus(1, 0);
      begin
        repeat (9) @(posedge Clock);
        ready_mode = 0;
      end
    join
    wait_idle();

    $display("[TB] randomized traffic");
    for (int n = 0; n < 150; n++) begin
      tick_mode  = $urandom_range(0, 2);
      ready_mode = $urandom_range(0, 1);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 4)) @(posedge Clock);
      end
      apply_stimulus($urandom_range(0, 3), 1);
    end
    tick_mode  = 0;
    ready_mode = 0;
    wait_idle();

    $display("[TB] reset during a slice select");
    apply_stimulus(2, 0);
    @(negedge Clock);
    #2 Reset = 1'b1;
    #1 reset_probe = 1'b1;
    #1 reset_probe = 1'b0;
    sb.delete();
    accepted_cnt <= taken_cnt;
    @(negedge Clock);
    #2 Reset = 1'b0;

    apply_stimulus(0, 1);
    wait_idle();
    repeat (3) @(negedge Clock);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
